// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32 ID stage: opcodes, control-field encodings and the
// packed control bundle carried from decode into the EX-facing register.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_BR    = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_MEXT  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } a_sel_e;

    typedef struct packed {
        logic    branch;
        logic    mem_read;
        logic    memto_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        logic    jump;
        logic    jalr;
        logic    illegal;
        alu_op_e alu_op;
        wb_sel_e wb_sel;
        a_sel_e  a_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NONE = ctrl_bundle_t'('0);

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I(+M) decoder: instruction word to control bundle plus
// register-usage flags consumed by the load-use hazard check.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit SUPPORT_M = 1'b0
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         uses_rs1,
    output logic         uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl     = CTRL_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_MEXT && !SUPPORT_M) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = (funct7 == F7_MEXT) ? ALU_MEXT : ALU_FUNCT;
                    uses_rs1       = 1'b1;
                    uses_rs2       = 1'b1;
                end
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = (funct3 == 3'b000) ? ALU_ADD : ALU_FUNCT;
                uses_rs1       = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.memto_reg = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.wb_sel    = WB_MEM;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BR;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.a_sel     = A_PC;
                ctrl.wb_sel    = WB_PC4;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    ctrl.jump      = 1'b1;
                    ctrl.jalr      = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.wb_sel    = WB_PC4;
                    uses_rs1       = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.a_sel     = A_ZERO;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.a_sel     = A_PC;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded; loads still access memory.
        if (instr[11:7] == 5'd0) ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered ID stage: decode, load-use hazard detection, valid/ready handshake,
// flush handling and a saturating count of inserted bubbles.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             branch,
    output logic             memRead,
    output logic             memtoReg,
    output logic             memWrite,
    output logic             ALUSrc,
    output logic             regWrite,
    output logic             jump,
    output logic             jalr,
    output logic             illegal,
    output logic [1:0]       ALUOp,
    output logic [1:0]       wbSel,
    output logic [1:0]       aSel,
    output logic [2:0]       funct3_o,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  pc_o,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_bundle_t dec_ctrl;
    ctrl_bundle_t ctrl_q;
    logic         uses_rs1;
    logic         uses_rs2;
    logic [4:0]   in_rs1;
    logic [4:0]   in_rs2;
    logic         hazard;
    logic         out_free;
    logic         bubble;
    logic         take;

    ctrl_decode_comb #(
        .SUPPORT_M (SUPPORT_M)
    ) u_decode (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign in_rs1 = in_instr[19:15];
    assign in_rs2 = in_instr[24:20];

    assign hazard   = in_valid && ex_memRead && (ex_rd != 5'd0) &&
                      ((uses_rs1 && in_rs1 == ex_rd) || (uses_rs2 && in_rs2 == ex_rd));
    assign out_free = !out_valid || out_ready;
    // A flush always drains fetch, even while EX is backpressuring.
    assign in_ready = flush || (!hazard && out_free);
    assign bubble   = hazard && out_free;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            ctrl_q    <= CTRL_NONE;
            funct3_o  <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            pc_o      <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (bubble) begin
            out_valid <= 1'b0;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end else if (take) begin
            out_valid <= 1'b1;
            ctrl_q    <= dec_ctrl;
            funct3_o  <= in_instr[14:12];
            rs1       <= in_rs1;
            rs2       <= in_rs2;
            rd        <= in_instr[11:7];
            pc_o      <= in_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign branch   = ctrl_q.branch;
    assign memRead  = ctrl_q.mem_read;
    assign memtoReg = ctrl_q.memto_reg;
    assign memWrite = ctrl_q.mem_write;
    assign ALUSrc   = ctrl_q.alu_src;
    assign regWrite = ctrl_q.reg_write;
    assign jump     = ctrl_q.jump;
    assign jalr     = ctrl_q.jalr;
    assign illegal  = ctrl_q.illegal;
    assign ALUOp    = ctrl_q.alu_op;
    assign wbSel    = ctrl_q.wb_sel;
    assign aSel     = ctrl_q.a_sel;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: two instances (RV32M off / on, different
// counter widths) share stimulus and are compared every cycle against a reference model.
module tb_ctrl_decode_stage;

    localparam int XLEN   = 32;
    localparam int CNT_W0 = 16;
    localparam int CNT_W1 = 3;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ADD  = 32'h001101B3;
    localparam logic [31:0] I_ONES = 32'hFFFFFFFF;
    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_MUL  = 32'h022080B3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, in_valid, flush, ex_memRead, out_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic [4:0]       ex_rd;

    logic             iready [2], ovalid [2], br [2], mrd [2], mtr [2], mwr [2];
    logic             asrc [2], rwr [2], jmp [2], jlr [2], ill [2];
    logic [1:0]       aop [2], wbs [2], asl [2];
    logic [2:0]       f3o [2];
    logic [4:0]       rs1o [2], rs2o [2], rdo [2];
    logic [XLEN-1:0]  pco [2];
    logic [CNT_W0-1:0] cnt0;
    logic [CNT_W1-1:0] cnt1;

    ctrl_decode_stage #(.XLEN(XLEN), .SUPPORT_M(1'b0), .CNT_W(CNT_W0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(iready[0]),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_memRead(ex_memRead),
        .ex_rd(ex_rd), .out_valid(ovalid[0]), .out_ready(out_ready),
        .branch(br[0]), .memRead(mrd[0]), .memtoReg(mtr[0]), .memWrite(mwr[0]),
        .ALUSrc(asrc[0]), .regWrite(rwr[0]), .jump(jmp[0]), .jalr(jlr[0]),
        .illegal(ill[0]), .ALUOp(aop[0]), .wbSel(wbs[0]), .aSel(asl[0]),
        .funct3_o(f3o[0]), .rs1(rs1o[0]), .rs2(rs2o[0]), .rd(rdo[0]),
        .pc_o(pco[0]), .stall_cnt(cnt0)
    );

    ctrl_decode_stage #(.XLEN(XLEN), .SUPPORT_M(1'b1), .CNT_W(CNT_W1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(iready[1]),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_memRead(ex_memRead),
        .ex_rd(ex_rd), .out_valid(ovalid[1]), .out_ready(out_ready),
        .branch(br[1]), .memRead(mrd[1]), .memtoReg(mtr[1]), .memWrite(mwr[1]),
        .ALUSrc(asrc[1]), .regWrite(rwr[1]), .jump(jmp[1]), .jalr(jlr[1]),
        .illegal(ill[1]), .ALUOp(aop[1]), .wbSel(wbs[1]), .aSel(asl[1]),
        .funct3_o(f3o[1]), .rs1(rs1o[1]), .rs2(rs2o[1]), .rd(rdo[1]),
        .pc_o(pco[1]), .stall_cnt(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Reference model: architectural state of one stage instance.
    typedef struct {
        bit              v;
        logic [14:0]     ctrl;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      f3;
        logic [XLEN-1:0] pc;
        int              cnt;
    } mstate_t;

    mstate_t m [2];
    bit      model_known = 1'b0;

    function automatic mstate_t zero_state();
        mstate_t s;
        s.v = 1'b0; s.ctrl = '0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.f3 = '0; s.pc = '0; s.cnt = 0;
        return s;
    endfunction

    // Decode table written from the ISA rules; packed as
    // {branch,memRead,memtoReg,memWrite,ALUSrc,regWrite,jump,jalr,illegal,ALUOp,wbSel,aSel}.
    function automatic void ref_decode(input logic [31:0] w, input bit sup_m,
                                       output logic [14:0] c, output bit u1, output bit u2);
        bit b_br, b_mr, b_mt, b_mw, b_as, b_rw, b_j, b_jr, b_il;
        logic [1:0] op, wb, as;
        {b_br, b_mr, b_mt, b_mw, b_as, b_rw, b_j, b_jr, b_il} = '0;
        op = 2'd0; wb = 2'd0; as = 2'd0; u1 = 1'b0; u2 = 1'b0;
        case (w[6:0])
            7'b0110011: if (w[31:25] == 7'b0000001 && !sup_m) b_il = 1'b1;
                        else begin b_rw = 1; op = (w[31:25] == 7'b0000001) ? 2'd3 : 2'd2; u1 = 1; u2 = 1; end
            7'b0010011: begin b_rw = 1; b_as = 1; op = (w[14:12] == 3'd0) ? 2'd0 : 2'd2; u1 = 1; end
            7'b0000011: begin b_rw = 1; b_mr = 1; b_mt = 1; b_as = 1; wb = 2'd1; u1 = 1; end
            7'b0100011: begin b_mw = 1; b_as = 1; u1 = 1; u2 = 1; end
            7'b1100011: begin b_br = 1; op = 2'd1; u1 = 1; u2 = 1; end
            7'b1101111: begin b_j = 1; b_rw = 1; b_as = 1; as = 2'd1; wb = 2'd2; end
            7'b1100111: if (w[14:12] == 3'd0) begin b_j = 1; b_jr = 1; b_rw = 1; b_as = 1; wb = 2'd2; u1 = 1; end
                        else b_il = 1'b1;
            7'b0110111: begin b_rw = 1; b_as = 1; as = 2'd2; end
            7'b0010111: begin b_rw = 1; b_as = 1; as = 2'd1; end
            default:    b_il = 1'b1;
        endcase
        if (w[11:7] == 5'd0) b_rw = 1'b0;
        c = {b_br, b_mr, b_mt, b_mw, b_as, b_rw, b_j, b_jr, b_il, op, wb, as};
    endfunction

    function automatic logic [14:0] obs_ctrl(input int k);
        return {br[k], mrd[k], mtr[k], mwr[k], asrc[k], rwr[k], jmp[k], jlr[k], ill[k],
                aop[k], wbs[k], asl[k]};
    endfunction

    function automatic logic [63:0] obs_cnt(input int k);
        return (k == 0) ? 64'(cnt0) : 64'(cnt1);
    endfunction

    // One clock: drive inputs, check in_ready before the edge, advance model, check outputs after.
    task automatic step(input logic r, input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [XLEN-1:0] pc, input logic exm, input logic [4:0] exr,
                        input logic ordy);
        mstate_t     nx [2];
        logic [14:0] c;
        bit          u1, u2, hz, rdy;
        int          cmax;
        reset = r; flush = fl; in_valid = iv; in_instr = ins; in_pc = pc;
        ex_memRead = exm; ex_rd = exr; out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) begin
            ref_decode(ins, k == 1, c, u1, u2);
            cmax = (k == 0) ? (1 << CNT_W0) - 1 : (1 << CNT_W1) - 1;
            hz   = iv && exm && (exr != 5'd0) &&
                   ((u1 && ins[19:15] == exr) || (u2 && ins[24:20] == exr));
            rdy  = fl || (!hz && (!m[k].v || ordy));
            if (model_known) check("in_ready", k, 64'(iready[k]), 64'(rdy));
            nx[k] = m[k];
            if (r) nx[k] = zero_state();
            else if (fl) nx[k].v = 1'b0;
            else if (hz && (!m[k].v || ordy)) begin
                nx[k].v = 1'b0;
                if (nx[k].cnt < cmax) nx[k].cnt++;
            end else if (iv && rdy) begin
                nx[k].v = 1'b1; nx[k].ctrl = c; nx[k].rs1 = ins[19:15]; nx[k].rs2 = ins[24:20];
                nx[k].rd = ins[11:7]; nx[k].f3 = ins[14:12]; nx[k].pc = pc;
            end else if (m[k].v && ordy) nx[k].v = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m[k] = nx[k];
            check("out_valid", k, 64'(ovalid[k]), 64'(m[k].v));
            check("stall_cnt", k, obs_cnt(k), 64'(m[k].cnt));
            if (m[k].v || r) begin
                check("ctrl", k, 64'(obs_ctrl(k)), 64'(m[k].ctrl));
                check("regs", k, 64'({rs1o[k], rs2o[k], rdo[k], f3o[k]}),
                      64'({m[k].rs1, m[k].rs2, m[k].rd, m[k].f3}));
                check("pc", k, 64'(pco[k]), 64'(m[k].pc));
            end
        end
        model_known = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        logic [31:0] w;
        int sel;
        w   = $urandom();
        sel = $urandom_range(0, 11);
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        if (sel < 9) begin
            w[6:0] = ops[sel];
            if (sel == 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0000000 : 7'b0100000;
            if (sel == 6 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
        end else if (sel == 9) begin
            w[6:0] = 7'b0110011;
            w[31:25] = 7'b0000001;
        end
        return w;
    endfunction

    initial begin
        m[0] = zero_state();
        m[1] = zero_state();
        reset = 1; flush = 0; in_valid = 0; in_instr = '0; in_pc = '0;
        ex_memRead = 0; ex_rd = '0; out_ready = 0;

        // Reset state
        step(1, 0, 0, I_NOP, 32'h0, 0, 5'd0, 1);
        step(1, 0, 0, I_NOP, 32'h0, 0, 5'd0, 1);
        check("reset_out_valid", 0, 64'(ovalid[0]), 64'd0);
        check("reset_ctrl", 0, 64'(obs_ctrl(0)), 64'd0);

        // ADDI x1,x0,5
        step(0, 0, 1, I_ADDI, 32'h100, 0, 5'd0, 1);
        check("addi_valid", 0, 64'(ovalid[0]), 64'd1);
        check("addi_aluop", 0, 64'(aop[0]), 64'd0);
        check("addi_alusrc", 0, 64'(asrc[0]), 64'd1);
        check("addi_regwrite", 0, 64'(rwr[0]), 64'd1);
        check("addi_rd", 0, 64'(rdo[0]), 64'd1);

        // Load-use: LW x2 in EX, ADD x3,x2,x1 incoming -> one bubble, then issue
        step(0, 0, 1, I_ADD, 32'h104, 1, 5'd2, 1);
        check("lu_bubble", 0, 64'(ovalid[0]), 64'd0);
        check("lu_stall_cnt", 0, 64'(cnt0), 64'd1);
        step(0, 0, 1, I_ADD, 32'h104, 0, 5'd0, 1);
        check("lu_issue_valid", 0, 64'(ovalid[0]), 64'd1);
        check("lu_issue_rd", 0, 64'(rdo[0]), 64'd3);

        // Backpressure for three cycles, one of them also a load-use hazard
        step(0, 0, 1, I_ADDI, 32'h108, 0, 5'd0, 0);
        step(0, 0, 1, I_ADD,  32'h108, 1, 5'd2, 0);
        step(0, 0, 1, I_ADDI, 32'h108, 0, 5'd0, 0);
        check("bp_rd_held", 0, 64'(rdo[0]), 64'd3);
        check("bp_stall_cnt", 0, 64'(cnt0), 64'd1);

        // Flush while held, then flush of a freshly loaded bundle
        step(0, 1, 1, I_ADDI, 32'h10C, 0, 5'd0, 0);
        check("flush_held", 0, 64'(ovalid[0]), 64'd0);
        step(0, 0, 1, I_ADDI, 32'h110, 0, 5'd0, 1);
        step(0, 1, 1, I_ADDI, 32'h114, 0, 5'd0, 1);
        check("flush_in", 0, 64'(ovalid[0]), 64'd0);

        // Illegal word, NOP, MUL in both configurations
        step(0, 0, 1, I_ONES, 32'h118, 0, 5'd0, 1);
        check("ones_illegal", 0, 64'(ill[0]), 64'd1);
        check("ones_flags", 0, 64'({rwr[0], mwr[0], br[0], jmp[0]}), 64'd0);
        step(0, 0, 1, I_NOP, 32'h11C, 0, 5'd0, 1);
        check("nop_regwrite", 0, 64'(rwr[0]), 64'd0);
        step(0, 0, 1, I_MUL, 32'h120, 0, 5'd0, 1);
        check("mul_m0_illegal", 0, 64'(ill[0]), 64'd1);
        check("mul_m1_aluop", 1, 64'(aop[1]), 64'd3);
        check("mul_m1_regwrite", 1, 64'(rwr[1]), 64'd1);

        // Reset during a load-use stall
        step(0, 0, 1, I_ADD, 32'h124, 1, 5'd1, 1);
        step(1, 0, 1, I_ADD, 32'h124, 1, 5'd1, 1);
        check("rst_stall_valid", 0, 64'(ovalid[0]), 64'd0);
        check("rst_stall_cnt", 0, 64'(cnt0), 64'd0);
        check("rst_stall_ctrl", 0, 64'(obs_ctrl(0)), 64'd0);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 9; i++) step(0, 0, 1, I_ADD, 32'h128, 1, 5'd2, 1);
        check("sat_narrow", 1, 64'(cnt1), 64'd7);
        check("sat_wide", 0, 64'(cnt0), 64'd9);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 8), rand_instr(), XLEN'($urandom()),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
